// File: rtl/cache_req_skid_buffer.sv
// -----------------------------------------------------------------------------
// cache_req_skid_buffer
//
// Two-entry valid/ready skid buffer placed directly in front of the
// clock-enabled request/data pipeline register on the cache request path.
// Every output is decoded from flops only. No combinational path exists from
// m_ready_i (or any other input) to s_ready_o or any other output.
//
// Handshake: a beat transfers on a port when valid and ready are both 1 at the
// rising edge of clk_i. A producer holds valid and payload until the transfer.
// While m_valid_o=1 and m_ready_i=0, m_valid_o and m_data_o hold steady.
//
// Ports
//   clk_i        clock, rising edge
//   rst_n_i      synchronous active-low reset
//   flush_i      synchronous flush, drops every held entry
//   s_valid_i    upstream request valid
//   s_ready_o    upstream ready (decoded from state register)
//   s_data_i     upstream payload [DATA_W-1:0]
//   m_valid_o    downstream valid (decoded from state register)
//   m_ready_i    downstream ready / clock enable of the next stage
//   m_data_o     downstream payload (main register) [DATA_W-1:0]
//   occupancy_o  entries held: 0, 1 or 2. Mirrors the FSM state for debug.
// -----------------------------------------------------------------------------
module cache_req_skid_buffer #(
    parameter int unsigned       DATA_W  = 21,
    parameter logic [DATA_W-1:0] RST_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              flush_i,
    input  logic              s_valid_i,
    output logic              s_ready_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [1:0]        occupancy_o
);

    // The encoding equals the number of held entries, so occupancy_o shows
    // the state directly. 2'd3 is illegal and recovers to EMPTY.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_EMPTY;
            main_q  <= RST_VAL;
            skid_q  <= RST_VAL;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // A flush wins over any handshake in the same cycle.
            // A concurrent upstream beat is discarded.
            state_d = ST_EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (s_valid_i) begin
                        main_d  = s_data_i;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    case ({s_valid_i, m_ready_i})
                        2'b11: main_d = s_data_i;  // push and pop together
                        2'b10: begin               // consumer stalled: park in skid
                            skid_d  = s_data_i;
                            state_d = ST_FULL;
                        end
                        2'b01: state_d = ST_EMPTY; // main goes stale, masked by valid
                        default: ;
                    endcase
                end
                ST_FULL: begin
                    // s_valid_i is ignored here because s_ready_o is 0.
                    if (m_ready_i) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        m_valid_o   = 1'b0;
        s_ready_o   = 1'b1;
        occupancy_o = 2'd0;
        case (state_q)
            ST_BUSY: begin
                m_valid_o   = 1'b1;
                occupancy_o = 2'd1;
            end
            ST_FULL: begin
                m_valid_o   = 1'b1;
                s_ready_o   = 1'b0;
                occupancy_o = 2'd2;
            end
            default: ;
        endcase
    end

    assign m_data_o = main_q;

endmodule

// File: tb/tb_cache_req_skid_buffer.sv
// -----------------------------------------------------------------------------
// Bench for cache_req_skid_buffer.
// The reference is a plain FIFO of at most two entries. Each rising edge
// updates it from the sampled inputs. The compare process checks the DUT
// against it on every falling edge. Directed sections check hand-computed
// literals, including the order of delivered beats.
// -----------------------------------------------------------------------------
module tb_cache_req_skid_buffer;

    localparam int W = 21;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_data;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic [1:0]   occ;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    logic [W-1:0] exp_q[$];  // reference contents, head = next beat out
    logic [W-1:0] dlv_q[$];  // beats seen leaving the DUT
    bit           model_live = 0;

    cache_req_skid_buffer #(.DATA_W(W), .RST_VAL({W{1'b0}})) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .flush_i    (flush),
        .s_valid_i  (s_valid),
        .s_ready_o  (s_ready),
        .s_data_i   (s_data),
        .m_valid_o  (m_valid),
        .m_ready_i  (m_ready),
        .m_data_o   (m_data),
        .occupancy_o(occ)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- check helper ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    always @(posedge clk) begin
        bit pop, push;
        if (!rst_n) begin
            exp_q.delete();
            model_live = 1;
        end else if (flush) begin
            exp_q.delete();
        end else begin
            pop  = (exp_q.size() > 0) && m_ready;
            push = s_valid && (exp_q.size() < 2);
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(s_data);
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (model_live) begin
            check("m_valid", {31'b0, m_valid}, {31'b0, exp_q.size() > 0});
            check("s_ready", {31'b0, s_ready}, {31'b0, exp_q.size() < 2});
            check("occupancy", {30'b0, occ}, exp_q.size());
            check("s_ready_vs_occ", {31'b0, s_ready}, {31'b0, occ != 2'd2});
            if (exp_q.size() > 0)
                check("m_data_head", {11'b0, m_data}, {11'b0, exp_q[0]});
            if (prev_hold) begin
                check("stall_valid", {31'b0, m_valid}, 32'd1);
                check("stall_data", {11'b0, m_data}, {11'b0, prev_data});
            end
            if (m_valid && m_ready && rst_n && !flush)
                dlv_q.push_back(m_data);
        end
        prev_hold = m_valid && !m_ready && rst_n && !flush;
        prev_data = m_data;
    end

    // ---------------- drivers ----------------
    // Inputs are applied 1 time unit after a rising edge. The next rising edge
    // samples them, and the caller resumes 1 time unit after that edge.
    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        s_valid = v;
        s_data  = d;
        m_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_dlv(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input int n);
        check({name, "_count"}, dlv_q.size(), n);
        if (n > 0 && dlv_q.size() > 0) check({name, "_0"}, {11'b0, dlv_q[0]}, {11'b0, a});
        if (n > 1 && dlv_q.size() > 1) check({name, "_1"}, {11'b0, dlv_q[1]}, {11'b0, b});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset held for two edges, with a request offered that must be ignored.
        step(1'b1, 21'h1F0F0, 1'b1);
        step(1'b1, 21'h1F0F0, 1'b1);
        check("rst_m_valid", {31'b0, m_valid}, 32'd0);
        check("rst_s_ready", {31'b0, s_ready}, 32'd1);
        check("rst_occ", {30'b0, occ}, 32'd0);
        check("rst_m_data", {11'b0, m_data}, 32'd0);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        check("idle_m_valid", {31'b0, m_valid}, 32'd0);

        // Streaming: one beat per cycle, one cycle of latency.
        dlv_q.delete();
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, W'(k), 1'b1);
            check("stream_occ", {30'b0, occ}, 32'd1);
            check("stream_data", {11'b0, m_data}, k);
        end
        step(1'b0, '0, 1'b1);
        check("stream_drained", {31'b0, m_valid}, 32'd0);
        check("stream_count", dlv_q.size(), 32'd8);
        for (int k = 0; k < 8; k++)
            if (k < dlv_q.size()) check("stream_order", {11'b0, dlv_q[k]}, k + 1);

        // Backpressure: fill both entries, stall, then drain.
        dlv_q.delete();
        step(1'b1, 21'h0000A, 1'b0);
        step(1'b1, 21'h0000B, 1'b0);
        check("bp_occ", {30'b0, occ}, 32'd2);
        check("bp_s_ready", {31'b0, s_ready}, 32'd0);
        check("bp_data", {11'b0, m_data}, 32'h0000A);
        step(1'b1, 21'h0000E, 1'b0);  // offered while full: not accepted
        check("bp_hold_data", {11'b0, m_data}, 32'h0000A);
        step(1'b0, '0, 1'b1);
        check("bp_ready_back", {31'b0, s_ready}, 32'd1);
        check("bp_second", {11'b0, m_data}, 32'h0000B);
        step(1'b0, '0, 1'b1);
        check("bp_empty", {31'b0, m_valid}, 32'd0);
        check_dlv("bp_dlv", 21'h0000A, 21'h0000B, 2);

        // Flush while full, with a concurrent request that must be dropped.
        dlv_q.delete();
        step(1'b1, 21'h00011, 1'b0);
        step(1'b1, 21'h00012, 1'b0);
        flush = 1'b1;
        step(1'b1, 21'h0000C, 1'b0);
        flush = 1'b0;
        check("flush_m_valid", {31'b0, m_valid}, 32'd0);
        check("flush_occ", {30'b0, occ}, 32'd0);
        check("flush_data", {11'b0, m_data}, 32'd0);
        check("flush_s_ready", {31'b0, s_ready}, 32'd1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        check_dlv("flush_dlv", '0, '0, 0);

        // Mid-operation reset while full.
        step(1'b1, 21'h00021, 1'b0);
        step(1'b1, 21'h00022, 1'b0);
        rst_n = 1'b0;
        step(1'b0, '0, 1'b0);
        rst_n = 1'b1;
        check("mrst_m_valid", {31'b0, m_valid}, 32'd0);
        check("mrst_occ", {30'b0, occ}, 32'd0);
        check("mrst_data", {11'b0, m_data}, 32'd0);

        // Reset glitch between edges has no effect.
        dlv_q.delete();
        step(1'b1, 21'h00031, 1'b0);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step(1'b0, '0, 1'b0);
        check("glitch_occ", {30'b0, occ}, 32'd1);
        check("glitch_data", {11'b0, m_data}, 32'h00031);
        step(1'b0, '0, 1'b1);
        check_dlv("glitch_dlv", 21'h00031, '0, 1);

        // Random valid/ready traffic with rare flushes.
        for (int i = 0; i < 10000; i++) begin
            flush = ($urandom_range(0, 99) == 0);
            step(1'($urandom_range(0, 3) != 0), W'($urandom_range(0, (1 << W) - 1)),
                 1'($urandom_range(0, 2) != 0));
        end
        flush = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
        check("final_empty", {31'b0, m_valid}, 32'd0);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
